// File: rtl/mdio_apb_arbiter_if.sv
// Bus bundle for mdio_apb_arbiter: two requester ports, the APB master port
// and the arbiter status outputs. The slave modport is the arbiter's view.
interface mdio_apb_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
);
    // requester 0 (MDIO request path)
    logic              m0_valid;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ready;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    // requester 1 (secondary host)
    logic              m1_valid;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ready;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    // APB master port
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    // status
    logic [1:0]        grant;
    logic              arb_busy;
    logic              timeout_evt;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata,
        output m0_ready, m0_rdata, m0_err,
        input  m1_valid, m1_we, m1_addr, m1_wdata,
        output m1_ready, m1_rdata, m1_err,
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr,
        output grant, arb_busy, timeout_evt
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata,
        input  m0_ready, m0_rdata, m0_err,
        output m1_valid, m1_we, m1_addr, m1_wdata,
        input  m1_ready, m1_rdata, m1_err,
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr,
        input  grant, arb_busy, timeout_evt
    );
endinterface

// File: rtl/mdio_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between the MDIO request
// path (requester 0) and the secondary host (requester 1). One transfer in
// flight at a time, full SETUP/ACCESS sequencing and an ACCESS timeout.
module mdio_apb_arbiter #(
    parameter int          ADDR_W  = 21,
    parameter int          DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk_100m,
    input logic            rst_100m,
    mdio_apb_arbiter_if.slave bus
);

    // Counter only has to reach TIMEOUT-1: the compare fires in the last
    // allowed ACCESS cycle so exactly TIMEOUT ACCESS cycles elapse.
    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [CNT_W-1:0]  cnt;

    logic              req_any;
    logic              pick1;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic [DATA_W-1:0] win_wdata;
    logic              acc_end;
    logic              acc_to;
    logic [DATA_W-1:0] acc_rdata;
    logic              acc_err;

    // Winner selection and ACCESS completion decode
    always_comb begin
        req_any   = bus.m0_valid | bus.m1_valid;
        pick1     = bus.m1_valid & (~bus.m0_valid | ~last_grant);
        win_addr  = pick1 ? bus.m1_addr  : bus.m0_addr;
        win_we    = pick1 ? bus.m1_we    : bus.m0_we;
        win_wdata = pick1 ? bus.m1_wdata : bus.m0_wdata;

        acc_to    = TO_EN && !bus.pready && (cnt == TO_LAST);
        acc_end   = bus.pready | acc_to;
        if (bus.pready) begin
            acc_rdata = bus.pwrite ? '0 : bus.prdata;
            acc_err   = bus.pslverr;
        end else begin
            acc_rdata = '1;
            acc_err   = 1'b1;
        end
    end

    // Arbitration FSM with registered APB, grant and requester outputs
    always_ff @(posedge clk_100m or posedge rst_100m) begin
        if (rst_100m) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            cnt             <= '0;
            bus.paddr       <= '0;
            bus.pwrite      <= 1'b0;
            bus.pwdata      <= '0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.grant       <= '0;
            bus.arb_busy    <= 1'b0;
            bus.timeout_evt <= 1'b0;
            bus.m0_ready    <= 1'b0;
            bus.m0_rdata    <= '0;
            bus.m0_err      <= 1'b0;
            bus.m1_ready    <= 1'b0;
            bus.m1_rdata    <= '0;
            bus.m1_err      <= 1'b0;
        end else begin
            bus.m0_ready    <= 1'b0;
            bus.m1_ready    <= 1'b0;
            bus.timeout_evt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        owner        <= pick1;
                        bus.paddr    <= win_addr;
                        bus.pwrite   <= win_we;
                        bus.pwdata   <= win_wdata;
                        bus.grant    <= pick1 ? 2'b10 : 2'b01;
                        bus.psel     <= 1'b1;
                        bus.penable  <= 1'b0;
                        bus.arb_busy <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    cnt         <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (acc_end) begin
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.timeout_evt <= acc_to;
                        if (owner) begin
                            bus.m1_ready <= 1'b1;
                            bus.m1_rdata <= acc_rdata;
                            bus.m1_err   <= acc_err;
                        end else begin
                            bus.m0_ready <= 1'b1;
                            bus.m0_rdata <= acc_rdata;
                            bus.m0_err   <= acc_err;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant   <= owner;
                    bus.grant    <= '0;
                    bus.arb_busy <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdio_apb_arbiter.md
Name: mdio_apb_arbiter

Overview:
- Shares the single APB register-bus master port between two requesters: requester 0 is the MDIO request path (sync or async selected), requester 1 is the secondary host (debug/test access).
- Round-robin arbitration, one outstanding transfer at a time, full APB setup/access sequencing and an access timeout.
- Sits in the 100 MHz domain, between the MDIO request mux and the chip register file.

Parameters:
ADDR_W, 21, register address width
DATA_W, 16, register data width
TIMEOUT, 255, max ACCESS cycles waiting for pready before forced termination; 0 disables the timeout

Ports:
clk_100m  in  1  clock
rst_100m  in  1  asynchronous reset, active-high
m0_valid  in  1  requester 0 request; held with stable fields until m0_ready
m0_we  in  1  requester 0 write(1)/read(0)
m0_addr  in  ADDR_W  requester 0 address
m0_wdata  in  DATA_W  requester 0 write data
m0_ready  out  1  one-cycle completion pulse to requester 0
m0_rdata  out  DATA_W  read data, valid with m0_ready
m0_err  out  1  error flag, valid with m0_ready
m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err  same as m0_*, for requester 1
paddr  out  ADDR_W  APB address
pwrite  out  1  APB write
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
pready  in  1  APB ready
prdata  in  DATA_W  APB read data
pslverr  in  1  APB slave error
grant  out  2  one-hot owner of the current transfer; 0 when idle
arb_busy  out  1  high whenever state != IDLE
timeout_evt  out  1  one-cycle pulse on forced termination

Behaviour:
Reset state:
- All outputs are registered and reset to 0; paddr and pwdata reset to 0.
- State = IDLE; last_grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-transfer aborts immediately: psel and penable drop and no ready pulse is issued. Requesters must re-issue after reset.

FSM states: IDLE, SETUP, ACCESS, DONE.

IDLE:
- If any mX_valid is high, select the winner:
  - Only one valid: that requester.
  - Both valid: the requester != last_grant.
- Latch the winner's addr/we/wdata into paddr/pwrite/pwdata, set grant, go to SETUP.

SETUP: psel=1, penable=0, timeout counter cleared; go to ACCESS.

ACCESS: psel=1, penable=1, counter increments each cycle.
- pready=1:
  - Capture prdata on reads; rdata = 0 on writes.
  - Capture pslverr into err.
  - Drop psel/penable; go to DONE.
- pready=0 and counter == TIMEOUT (TIMEOUT != 0):
  - Drop psel/penable; rdata = {DATA_W{1}}, err = 1, timeout_evt = 1 for one cycle; go to DONE.
- pready at the same cycle the counter hits TIMEOUT: pready wins, normal completion, no timeout_evt.

DONE:
- The granted requester's mX_ready = 1 for exactly this cycle, with rdata/err valid.
- The other requester's ready stays 0 and its rdata/err outputs hold.
- last_grant = winner, grant = 0, go to IDLE.

Handshake and output rules:
- Requesters deassert valid in the cycle after sampling ready. The arbiter does not re-sample a requester's valid during DONE.
- paddr/pwrite/pwdata stay stable from SETUP through ACCESS, then hold their last value.
- mX_rdata/mX_err hold their last value between transfers.

Latency:
- Request sampled in IDLE at cycle N: SETUP at N+1, ACCESS at N+2, ready at N+3 + (pready wait cycles). Minimum 3 cycles.
- Back-to-back transfers: IDLE, SETUP, ACCESS, DONE = 4 cycles per zero-wait transfer.

Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Requests arriving while busy wait in their requester (valid held) and are never dropped.

Test Plan:
1. Single read, zero wait: m0 read addr 21'h00123, pready=1 in first ACCESS cycle with prdata=16'hBEEF -> psel high 2 cycles (penable in 2nd), m0_ready pulses 3 cycles after valid sampled, m0_rdata=16'hBEEF, m0_err=0.
2. Write with wait states: m1 write addr 21'h1F000, wdata 16'h5A5A, pready delayed 4 cycles -> paddr/pwdata/pwrite stable throughout, m1_ready after 4 extra ACCESS cycles, m1_rdata=0.
3. Tie after reset: m0 and m1 valid in the same cycle -> m0 granted first, m1 next. Both held continuously for 4 transfers -> grant order 0,1,0,1.
4. Timeout with TIMEOUT=8: m0 read, pready never asserted -> after 8 ACCESS cycles timeout_evt pulses once, m0_rdata=16'hFFFF, m0_err=1. Next request proceeds normally.
5. Slave error plus boundary: pslverr=1 with pready -> m1_err=1. Separately, pready at exactly the TIMEOUT count -> normal completion, timeout_evt=0.
6. Reset mid-ACCESS: assert rst_100m while psel=1 -> psel/penable/grant/arb_busy go 0 asynchronously, no ready pulse. After release, m0 wins the first tie.
